// File: rtl/vdp_pkg.sv
// Shared video-subsystem constants and types: frame geometry, pixel/address
// widths and the write-arbiter state encoding.
package vdp_pkg;

    localparam int FRAME_W      = 280;
    localparam int FRAME_H      = 192;
    localparam int FRAME_PIXELS = FRAME_W * FRAME_H;
    localparam int PIX_W        = 24;
    localparam int VADR_W       = 16;

    typedef logic [PIX_W-1:0]  pixel_t;
    typedef logic [VADR_W-1:0] vadr_t;

    typedef enum logic {
        ARB_IDLE,
        ARB_FILL
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted valid at or above ptr,
// wrapping modulo NREQ, returned as one-hot grant plus binary index.
module rr_pick #(
    parameter int NREQ = 3,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx,
    output logic            any
);

    always_comb begin
        int j;
        j   = 0;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!any && valid[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/vram_wr_arb.sv
// VRAM write-port arbiter: round-robin sharing among NREQ pixel producers,
// with a frame-fill engine that takes the port exclusively while clearing.
module vram_wr_arb
    import vdp_pkg::*;
#(
    parameter int DW     = PIX_W,
    parameter int AW     = VADR_W,
    parameter int NREQ   = 3,
    parameter int PIXELS = FRAME_PIXELS
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic [NREQ-1:0]  req_valid,
    output logic [NREQ-1:0]  req_ready,
    input  logic [NREQ*AW-1:0] req_adr,
    input  logic [NREQ*DW-1:0] req_d,
    input  logic             clr_start,
    input  logic [DW-1:0]    clr_color,
    output logic             clr_busy,
    output logic             clr_done,
    output logic             vram_we,
    output logic [AW-1:0]    vram_wadr,
    output logic [DW-1:0]    vram_d,
    output logic [2:0]       gnt_id
);

    localparam int IW = $clog2(NREQ);
    localparam logic [AW-1:0] LAST = AW'(PIXELS - 1);

    arb_state_t      state;
    logic [IW-1:0]   rr_ptr;
    logic [AW-1:0]   cnt;
    logic [DW-1:0]   color;

    logic [NREQ-1:0] pick_gnt;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;
    logic            accept;
    logic [AW-1:0]   sel_adr;
    logic [DW-1:0]   sel_d;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // A fill request wins over requesters presented in the same cycle.
    always_comb begin
        req_ready = '0;
        accept    = 1'b0;
        if (!reset && state == ARB_IDLE && !clr_start) begin
            req_ready = pick_gnt;
            accept    = pick_any;
        end
    end

    always_comb begin
        sel_adr = '0;
        sel_d   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_gnt[i]) begin
                sel_adr = req_adr[i*AW +: AW];
                sel_d   = req_d[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state     <= ARB_IDLE;
            rr_ptr    <= '0;
            cnt       <= '0;
            color     <= '0;
            vram_we   <= 1'b0;
            vram_wadr <= '0;
            vram_d    <= '0;
            gnt_id    <= '0;
            clr_busy  <= 1'b0;
            clr_done  <= 1'b0;
        end else begin
            vram_we  <= 1'b0;
            clr_done <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (clr_start) begin
                        state    <= ARB_FILL;
                        color    <= clr_color;
                        cnt      <= '0;
                        clr_busy <= 1'b1;
                    end else if (accept) begin
                        vram_we   <= 1'b1;
                        vram_wadr <= sel_adr;
                        vram_d    <= sel_d;
                        gnt_id    <= 3'(pick_idx);
                        rr_ptr    <= (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
                    end
                end
                ARB_FILL: begin
                    vram_we   <= 1'b1;
                    vram_wadr <= cnt;
                    vram_d    <= color;
                    // Busy drops in the same cycle done pulses with the last write.
                    if (cnt == LAST) begin
                        state    <= ARB_IDLE;
                        clr_done <= 1'b1;
                        clr_busy <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vram_wr_arb.sv
// Bench for vram_wr_arb: table-driven arbitration vectors, hand-written fill,
// reset-abort and backpressure sequences, and a write scoreboard.
module tb_vram_wr_arb;

    localparam int DW     = 24;
    localparam int AW     = 16;
    localparam int NREQ   = 3;
    localparam int PIXELS = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*AW-1:0] req_adr;
    logic [NREQ*DW-1:0] req_d;
    logic              clr_start;
    logic [DW-1:0]     clr_color;
    logic              clr_busy, clr_done, vram_we;
    logic [AW-1:0]     vram_wadr;
    logic [DW-1:0]     vram_d;
    logic [2:0]        gnt_id;

    vram_wr_arb #(.DW(DW), .AW(AW), .NREQ(NREQ), .PIXELS(PIXELS)) dut (
        .CLOCK_50  (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_adr   (req_adr),
        .req_d     (req_d),
        .clr_start (clr_start),
        .clr_color (clr_color),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done),
        .vram_we   (vram_we),
        .vram_wadr (vram_wadr),
        .vram_d    (vram_d),
        .gnt_id    (gnt_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] adr;
        logic [DW-1:0] d;
        logic [2:0]    id;
        bit            chk_id;
        bit            done;
        bit            busy;
        int            due;
    } wr_t;

    typedef struct {
        bit        rst;
        logic [2:0] valid;
        logic [2:0] exp_ready;
        logic [7:0] tag;
    } vec_t;

    wr_t  q[$];
    int   cyc_n = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc_n);
        end
    endtask

    // Scoreboard: every VRAM write must match the oldest expected write.
    initial begin
        wr_t e;
        forever begin
            @(posedge clk);
            #3;
            if (vram_we === 1'b1) begin
                if (q.size() == 0) begin
                    chk("unexpected_write", {16'h0, vram_wadr}, 32'hFFFF_FFFF);
                end else begin
                    e = q.pop_front();
                    chk("wr_cycle", cyc_n, e.due);
                    chk("wr_adr", {16'h0, vram_wadr}, {16'h0, e.adr});
                    chk("wr_d", {8'h0, vram_d}, {8'h0, e.d});
                    if (e.chk_id) chk("wr_gnt_id", {29'h0, gnt_id}, {29'h0, e.id});
                    chk("wr_done", {31'h0, clr_done}, {31'h0, e.done});
                    chk("wr_busy", {31'h0, clr_busy}, {31'h0, e.busy});
                end
            end else begin
                chk("idle_done", {31'h0, clr_done}, 32'h0);
                if (q.size() > 0 && q[0].due <= cyc_n) begin
                    e = q.pop_front();
                    chk("missing_write", {16'h0, vram_wadr}, {16'h0, e.adr});
                end
            end
        end
    end

    task automatic drive(input logic [2:0] v, input logic [3*AW-1:0] a,
                         input logic [3*DW-1:0] dd, input logic [2:0] exp_rdy,
                         input logic cs, input logic [DW-1:0] col, input string nm);
        wr_t e;
        req_valid = v;
        req_adr   = a;
        req_d     = dd;
        clr_start = cs;
        clr_color = col;
        #1;
        chk({nm, "_ready"}, {29'h0, req_ready}, {29'h0, exp_rdy});
        for (int i = 0; i < NREQ; i++) begin
            if (exp_rdy[i]) begin
                e = '{adr: a[i*AW +: AW], d: dd[i*DW +: DW], id: 3'(i),
                      chk_id: 1'b1, done: 1'b0, busy: 1'b0, due: cyc_n + 1};
                q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_fill(input logic [DW-1:0] col);
        wr_t e;
        for (int i = 0; i < PIXELS; i++) begin
            e = '{adr: AW'(i), d: col, id: 3'd0, chk_id: 1'b0,
                  done: (i == PIXELS - 1), busy: (i != PIXELS - 1), due: cyc_n + 2 + i};
            q.push_back(e);
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        clr_start = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    function automatic logic [3*AW-1:0] mk_adr(input logic [7:0] t);
        return {16'h2000 | 16'(t), 16'h1000 | 16'(t), 16'(t)};
    endfunction

    function automatic logic [3*DW-1:0] mk_d(input logic [7:0] t);
        return {24'h030000 | 24'(t), 24'h020000 | 24'(t), 24'h010000 | 24'(t)};
    endfunction

    vec_t vecs[14];

    initial begin
        vecs[0]  = '{1, 3'b111, 3'b001, 8'h11};
        vecs[1]  = '{0, 3'b111, 3'b010, 8'h11};
        vecs[2]  = '{0, 3'b111, 3'b100, 8'h11};
        vecs[3]  = '{0, 3'b111, 3'b001, 8'h11};
        vecs[4]  = '{0, 3'b111, 3'b010, 8'h11};
        vecs[5]  = '{0, 3'b111, 3'b100, 8'h11};
        vecs[6]  = '{1, 3'b110, 3'b010, 8'h22};
        vecs[7]  = '{0, 3'b110, 3'b100, 8'h22};
        vecs[8]  = '{0, 3'b110, 3'b010, 8'h22};
        vecs[9]  = '{0, 3'b110, 3'b100, 8'h22};
        vecs[10] = '{1, 3'b000, 3'b000, 8'h33};
        vecs[11] = '{0, 3'b100, 3'b100, 8'h34};
        vecs[12] = '{0, 3'b101, 3'b001, 8'h35};
        vecs[13] = '{0, 3'b101, 3'b100, 8'h35};

        // Reset state, with requesters asserting during reset.
        reset     = 1'b1;
        req_valid = 3'b111;
        req_adr   = mk_adr(8'h01);
        req_d     = mk_d(8'h01);
        clr_start = 1'b0;
        clr_color = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we", {31'h0, vram_we}, 32'h0);
        chk("rst_wadr", {16'h0, vram_wadr}, 32'h0);
        chk("rst_d", {8'h0, vram_d}, 32'h0);
        chk("rst_gnt_id", {29'h0, gnt_id}, 32'h0);
        chk("rst_busy", {31'h0, clr_busy}, 32'h0);
        chk("rst_done", {31'h0, clr_done}, 32'h0);
        chk("rst_ready", {29'h0, req_ready}, 32'h0);
        reset     = 1'b0;
        req_valid = '0;

        // Single write from requester 0.
        drive(3'b001, {32'h0, 16'h0010}, {48'h0, 24'hFFFFFF}, 3'b001, 1'b0, '0, "single");
        chk("single_we", {31'h0, vram_we}, 32'h1);
        drive(3'b000, '0, '0, 3'b000, 1'b0, '0, "single_idle");
        chk("single_we_off", {31'h0, vram_we}, 32'h0);

        // Round-robin table.
        for (int k = 0; k < 14; k++) begin
            if (vecs[k].rst) do_reset();
            drive(vecs[k].valid, mk_adr(vecs[k].tag), mk_d(vecs[k].tag),
                  vecs[k].exp_ready, 1'b0, '0, "rr");
        end
        drive(3'b000, '0, '0, 3'b000, 1'b0, '0, "rr_idle");

        // Fill colliding with req0; a second start mid-fill is ignored.
        do_reset();
        push_fill(24'h123456);
        drive(3'b001, mk_adr(8'h40), mk_d(8'h40), 3'b000, 1'b1, 24'h123456, "fill_start");
        chk("fill_busy_early", {31'h0, clr_busy}, 32'h1);
        for (int k = 0; k < PIXELS; k++)
            drive(3'b001, mk_adr(8'h40), mk_d(8'h40), 3'b000, (k == 3), 24'h654321, "fill");
        drive(3'b001, mk_adr(8'h41), mk_d(8'h41), 3'b001, 1'b0, '0, "post_fill");
        chk("post_fill_busy", {31'h0, clr_busy}, 32'h0);
        drive(3'b000, '0, '0, 3'b000, 1'b0, '0, "post_fill_idle");

        // Reset while fill write 3 is on the port: aborted, no done pulse.
        push_fill(24'h00ABCD);
        drive(3'b000, '0, '0, 3'b000, 1'b1, 24'h00ABCD, "abort_start");
        for (int k = 0; k < 4; k++) drive(3'b000, '0, '0, 3'b000, 1'b0, '0, "abort_run");
        chk("abort_at_adr3", {16'h0, vram_wadr}, 32'h3);
        while (q.size() > 0 && q[$].due > cyc_n) void'(q.pop_back());
        reset     = 1'b1;
        req_valid = 3'b111;
        @(posedge clk);
        #2;
        chk("abort_we", {31'h0, vram_we}, 32'h0);
        chk("abort_wadr", {16'h0, vram_wadr}, 32'h0);
        chk("abort_d", {8'h0, vram_d}, 32'h0);
        chk("abort_busy", {31'h0, clr_busy}, 32'h0);
        chk("abort_done", {31'h0, clr_done}, 32'h0);
        chk("abort_ready", {29'h0, req_ready}, 32'h0);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        req_valid = '0;
        push_fill(24'h777777);
        drive(3'b000, '0, '0, 3'b000, 1'b1, 24'h777777, "refill_start");
        for (int k = 0; k < PIXELS + 1; k++) drive(3'b000, '0, '0, 3'b000, 1'b0, '0, "refill");

        // Backpressure: req1 held with 0xAA while req0 streams.
        do_reset();
        drive(3'b011, {16'h0, 16'h0AA0, 16'h0001}, {24'h0, 24'h0000AA, 24'h000101}, 3'b001, 1'b0, '0, "bp0");
        drive(3'b011, {16'h0, 16'h0AA0, 16'h0002}, {24'h0, 24'h0000AA, 24'h000102}, 3'b010, 1'b0, '0, "bp1");
        drive(3'b001, {16'h0, 16'h0000, 16'h0003}, {24'h0, 24'h000000, 24'h000103}, 3'b001, 1'b0, '0, "bp2");
        drive(3'b001, {16'h0, 16'h0000, 16'h0004}, {24'h0, 24'h000000, 24'h000104}, 3'b001, 1'b0, '0, "bp3");
        drive(3'b000, '0, '0, 3'b000, 1'b0, '0, "bp_idle");

        repeat (4) @(posedge clk);
        #4;
        chk("queue_drained", q.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
